// File: rtl/cache_refill_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// refill_pkg
// Shared constants for the L1 refill arbiter:
//   - FSM state encoding (IDLE / ISSUE / RESP)
//   - owner encoding (instruction side = 0, data side = 1)
//   - default address / data / instruction widths
// -----------------------------------------------------------------------------
package refill_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    // Requester identity, also the value presented on the owner output
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Default widths
    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_INSTR_W = 32;

    // Round-robin pick between the two L1 sides given the last granted side.
    function automatic logic rr_pick(input logic inst_req,
                                     input logic data_req,
                                     input logic last_grant);
        logic pick;
        if (inst_req && data_req) begin
            pick = ~last_grant;
        end else if (data_req) begin
            pick = OWNER_D;
        end else begin
            pick = OWNER_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_refill_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-request round-robin arbiter. The grant is combinational from the two
// requests and the internal last-grant register; the parent decides when a
// grant has actually been consumed and pulses update_en with the owner.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   inst_req        instruction-side request
//   data_req        data-side request
//   update_en       commit update_owner into the last-grant register
//   update_owner    side that completed a transaction
//   grant_valid     at least one request present
//   grant           winning side (OWNER_I / OWNER_D)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import refill_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    input  logic update_en,
    input  logic update_owner,
    output logic grant_valid,
    output logic grant
);

    logic last_grant_r;
    logic grant_valid_s;
    logic grant_s;

    // Last-grant register; resets to the instruction side so data wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= OWNER_I;
        end else if (update_en) begin
            last_grant_r <= update_owner;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Combinational round-robin pick
    always_comb begin
        grant_valid_s = inst_req | data_req;
        grant_s       = rr_pick(inst_req, data_req, last_grant_r);
    end

    assign grant_valid = grant_valid_s;
    assign grant       = grant_s;

endmodule

// File: rtl/cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_refill_arbiter
// Shares the single backing-memory port between the L1 instruction cache and
// the L1 data cache on misses. One requester is chosen per transaction by a
// two-way round-robin, the memory handshake is driven until mem_ack, and the
// fill data is returned with a one-cycle done pulse to the winning side.
//
// Optional feature: define REFILL_TIMEOUT_EN to abort an ISSUE phase that
// waits TIMEOUT cycles without mem_ack; the transaction then completes with
// zero data and err pulses together with done.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_addr              instruction miss request / address
//   i_done, i_rdata            instruction completion pulse / fill word
//   d_req, d_we, d_addr,       data request / write flag / address /
//   d_wdata                    write value
//   d_done, d_rdata            data completion pulse / fill data
//   mem_req, mem_we, mem_addr, memory request (held until mem_ack) and
//   mem_wdata                  its registered fields
//   mem_ack, mem_rdata         memory completion with same-cycle read data
//   stall                      a requester is waiting and not yet completed
//   busy                       FSM not in IDLE
//   owner                      current or last owner (0 = instr, 1 = data)
//   err                        timeout pulse, coincident with done
// -----------------------------------------------------------------------------
module cache_refill_arbiter
    import refill_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
`ifdef REFILL_TIMEOUT_EN
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int TIMEOUT = 255
`else
    parameter int INSTR_W = DEF_INSTR_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_done,
    output logic [INSTR_W-1:0] i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_done,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall,
    output logic               busy,
    output logic               owner,
    output logic               err
);

    logic [1:0]         state_r;
    logic               owner_r;
    logic               busy_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_wdata_r;
    logic               i_done_r;
    logic               d_done_r;
    logic [INSTR_W-1:0] i_rdata_r;
    logic [DATA_W-1:0]  d_rdata_r;

    logic               grant_valid_s;
    logic               grant_s;
    logic               rr_update_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic               sel_we_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic               issue_entry_s;

    // Requests are only considered while idle; last-grant advances in RESP
    assign rr_update_s   = (state_r == RESP);
    assign issue_entry_s = (state_r == IDLE) && grant_valid_s;

    rr_arbiter2 u_rr (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (i_req),
        .data_req     (d_req),
        .update_en    (rr_update_s),
        .update_owner (owner_r),
        .grant_valid  (grant_valid_s),
        .grant        (grant_s)
    );

    // Fields of the winning requester; the instruction side never writes
    always_comb begin
        sel_addr_s  = i_addr;
        sel_we_s    = 1'b0;
        sel_wdata_s = '0;
        if (grant_s == OWNER_D) begin
            sel_addr_s  = d_addr;
            sel_we_s    = d_we;
            sel_wdata_s = d_wdata;
        end else begin
            sel_addr_s  = i_addr;
            sel_we_s    = 1'b0;
            sel_wdata_s = '0;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;
    logic             err_r;

    // ISSUE wait counter: cleared on entry, counts cycles without mem_ack
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (issue_entry_s) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ISSUE) && !mem_ack && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_hit_s = (state_r == ISSUE) && (tmo_cnt_r == TMO_W'(TIMEOUT));
`endif

    // Main refill FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWNER_I;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
`ifdef REFILL_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
        end else begin
            // done / err are single-cycle pulses unless set below
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            err_r    <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r     <= ISSUE;
                        owner_r     <= grant_s;
                        busy_r      <= 1'b1;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        state_r   <= RESP;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (owner_r == OWNER_D) begin
                            d_rdata_r <= mem_rdata;
                            d_done_r  <= 1'b1;
                        end else begin
                            i_rdata_r <= mem_rdata[INSTR_W-1:0];
                            i_done_r  <= 1'b1;
                        end
`ifdef REFILL_TIMEOUT_EN
                    end else if (tmo_hit_s) begin
                        // Abort: complete with zero data and flag the error
                        state_r   <= RESP;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        err_r     <= 1'b1;
                        if (owner_r == OWNER_D) begin
                            d_rdata_r <= '0;
                            d_done_r  <= 1'b1;
                        end else begin
                            i_rdata_r <= '0;
                            i_done_r  <= 1'b1;
                        end
`endif
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign i_done    = i_done_r;
    assign d_done    = d_done_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

    // Stall tracks the live requests, masked in the cycle of their own done
    assign stall = (i_req & ~i_done_r) | (d_req & ~d_done_r);

`ifdef REFILL_TIMEOUT_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_arbiter
// Directed stimulus with a scoreboard: expected memory requests and expected
// completions are queued by the stimulus; a monitor compares them against the
// DUT whenever mem_req is active or a done pulse appears.
// -----------------------------------------------------------------------------
module tb_cache_refill_arbiter;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic        side;
        logic [63:0] data;
        logic        err;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall;
    logic        busy;
    logic        owner;
    logic        err;

    int    n_tests = 0;
    int    n_fail  = 0;
    mreq_t mem_q[$];
    done_t done_q[$];
    mreq_t cur_req;
    logic  prev_mem_req = 1'b0;

    always #5 clk = ~clk;

`ifdef REFILL_TIMEOUT_EN
    cache_refill_arbiter #(.TIMEOUT(4)) dut (
`else
    cache_refill_arbiter dut (
`endif
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy), .owner(owner), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge; monitors sample on it
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [63:0] a, input logic we, input logic [63:0] wd);
        mreq_t m;
        m.addr = a; m.we = we; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    task automatic push_done(input logic side, input logic [63:0] data, input logic e);
        done_t x;
        x.side = side; x.data = data; x.err = e;
        done_q.push_back(x);
    endtask

    // Wait for mem_req, ack k cycles later with rdata, then release a requester
    task automatic serve(input int k, input logic [63:0] rdata, input int drop);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            step();
            n++;
        end
        check("serve_mem_req_seen", {63'd0, mem_req}, 64'd1);
        if (mem_req) begin
            repeat (k) step();
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 64'd0;
            if (drop == 1) i_req = 1'b0;
            else if (drop == 2) d_req = 1'b0;
        end
    endtask

    // Scoreboard monitor: memory-side requests and completion pulses
    always @(negedge clk) begin
        if (mem_req) begin
            if (!prev_mem_req) begin
                if (mem_q.size() == 0) begin
                    check("mem_req_unexpected", 64'd1, 64'd0);
                    cur_req = '0;
                end else begin
                    cur_req = mem_q.pop_front();
                end
            end
            check("mem_addr", mem_addr, cur_req.addr);
            check("mem_we", {63'd0, mem_we}, {63'd0, cur_req.we});
            check("mem_wdata", mem_wdata, cur_req.wdata);
        end
        prev_mem_req = mem_req;
        if (i_done || d_done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", {62'd0, i_done, d_done}, 64'd0);
            end else begin
                done_t e;
                e = done_q.pop_front();
                check("done_side", {62'd0, i_done, d_done}, {62'd0, ~e.side, e.side});
                if (e.side) check("d_rdata", d_rdata, e.data);
                else        check("i_rdata", {32'd0, i_rdata}, e.data);
                check("done_err", {63'd0, err}, {63'd0, e.err});
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; i_req = 1'b0; i_addr = 64'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
        mem_ack = 1'b0; mem_rdata = 64'd0;
        repeat (3) step();

        // Reset state
        check("rst_ctrl", {56'd0, mem_req, mem_we, i_done, d_done, err, busy, owner, stall}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_rdata", {32'd0, i_rdata} | d_rdata, 64'd0);
        reset = 1'b0;
        step();

        // Single instruction miss, ack 3 cycles after mem_req
        i_addr = 64'h40; i_req = 1'b1;
        push_mem(64'h40, 1'b0, 64'd0);
        push_done(1'b0, 64'h0000_0013, 1'b0);
        serve(3, 64'hDEAD_BEEF_0000_0013, 1);

        // Minimum latency: ack in the first ISSUE cycle
        step();
        i_addr = 64'h80; i_req = 1'b1;
        push_mem(64'h80, 1'b0, 64'd0);
        push_done(1'b0, 64'h2222_2222, 1'b0);
        step();
        check("lat_mem_req", {63'd0, mem_req}, 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h1111_1111_2222_2222;
        step();
        check("lat_i_done", {63'd0, i_done}, 64'd1);
        mem_ack = 1'b0; mem_rdata = 64'd0; i_req = 1'b0;
        step();

        // Tie after reset: data first, then instruction, then data again
        reset = 1'b1; step(); reset = 1'b0;
        i_addr = 64'h200; d_addr = 64'h300; i_req = 1'b1; d_req = 1'b1;
        push_mem(64'h300, 1'b0, 64'd0);  push_done(1'b1, 64'hA, 1'b0);
        push_mem(64'h200, 1'b0, 64'd0);  push_done(1'b0, 64'hB, 1'b0);
        push_mem(64'h308, 1'b0, 64'd0);  push_done(1'b1, 64'hC, 1'b0);
        step();
        check("tie1_owner", {63'd0, owner}, 64'd1);
        check("tie1_busy", {63'd0, busy}, 64'd1);
        serve(1, 64'hA, 0);
        d_addr = 64'h308;
        step();
        step();
        check("tie2_owner", {63'd0, owner}, 64'd0);
        serve(0, 64'hB, 1);
        serve(2, 64'hC, 2);

        // Data write held until ack
        step();
        d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h55; d_req = 1'b1;
        push_mem(64'h100, 1'b1, 64'h55);
        push_done(1'b1, 64'h77, 1'b0);
        serve(2, 64'h77, 2);
        d_we = 1'b0; d_wdata = 64'd0;
        step();
        check("wr_mem_we_after", {63'd0, mem_we}, 64'd0);

        // Stall while data waits behind an instruction transaction
        i_addr = 64'h500; i_req = 1'b1;
        push_mem(64'h500, 1'b0, 64'd0);
        push_done(1'b0, 64'h9ABC_DEF0, 1'b0);
        step();
        d_addr = 64'h600; d_req = 1'b1;
        push_mem(64'h600, 1'b0, 64'd0);
        push_done(1'b1, 64'h42, 1'b0);
        step();
        check("stall_both", {63'd0, stall}, 64'd1);
        serve(3, 64'h1234_5678_9ABC_DEF0, 1);
        check("stall_d_pending", {63'd0, stall}, 64'd1);
        serve(1, 64'h42, 2);
        check("stall_clear", {63'd0, stall}, 64'd0);
        check("i_rdata_hold", {32'd0, i_rdata}, 64'h9ABC_DEF0);

        // Reset during ISSUE: no done, stray ack ignored
        step();
        d_addr = 64'h900; d_req = 1'b1;
        push_mem(64'h900, 1'b0, 64'd0);
        step();
        check("rsti_mem_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        step();
        check("rsti_mem_req_drop", {63'd0, mem_req}, 64'd0);
        reset = 1'b0; d_req = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        step();
        step();
        check("rsti_idle", {62'd0, busy, mem_req}, 64'd0);
        check("rsti_d_rdata", d_rdata, 64'd0);

`ifdef REFILL_TIMEOUT_EN
        // Timeout abort with a pending data request granted afterwards
        i_addr = 64'h700; i_req = 1'b1;
        push_mem(64'h700, 1'b0, 64'd0);
        push_done(1'b0, 64'd0, 1'b1);
        step();
        d_addr = 64'h800; d_req = 1'b1;
        push_mem(64'h800, 1'b0, 64'd0);
        push_done(1'b1, 64'h99, 1'b0);
        n = 0;
        while (!i_done && n < 30) begin
            step();
            n++;
        end
        check("tmo_done_err", {62'd0, i_done, err}, 64'd3);
        i_req = 1'b0;
        serve(1, 64'h99, 2);
`endif
        n = 0;
        repeat (4) step();

        check("mem_q_empty", 64'(mem_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Shares the single backing-memory port (L2/main memory side) between the L1 instruction cache and the L1 data cache on misses. Each L1 raises a request with its miss address. The arbiter picks one requester per transaction using two-way round-robin, drives the memory handshake, and returns the fill data with a one-cycle done pulse. It sits between the L1 caches and the L2/memory path and drives the pipeline stall.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width on the memory port and data side
- INSTR_W, 32, instruction width returned to the instruction side
- TIMEOUT, 255, maximum ISSUE cycles before abort (only with the macro)

- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction-side miss request (level)
- i_addr  in  ADDR_W  instruction miss address
- i_done  out  1  one-cycle completion pulse to the instruction side
- i_rdata  out  INSTR_W  fill word, valid when i_done=1
- d_req  in  1  data-side miss request (level)
- d_we  in  1  data request is a write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_done  out  1  one-cycle completion pulse to the data side
- d_rdata  out  DATA_W  fill data, valid when d_done=1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- stall  out  1  a requester is waiting and not yet completed
- busy  out  1  state is not IDLE
- owner  out  1  current or last owner (0 = instruction, 1 = data)
- err  out  1  timeout pulse, coincident with done

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, with i_req or d_req high:
  - select a winner;
  - register the winner's addr, we and wdata (we is forced to 0 for the instruction side);
  - go to ISSUE.
- IDLE with no request: stay in IDLE.
- Winner selection:
  - a single request wins;
  - on a tie, the requester not granted last wins;
  - the last-grant register resets to instruction, so data wins the first tie.
- ISSUE:
  - mem_req=1 with the registered fields held stable;
  - on mem_ack, capture mem_rdata and go to RESP.
- RESP:
  - pulse the winner's done;
  - i_rdata = captured[INSTR_W-1:0], d_rdata = captured data;
  - update last-grant to the winner;
  - go to IDLE.
- Requests are sampled only in IDLE. A req still high in RESP is ignored. A req still high on the return to IDLE counts as a new request. Requesters must hold address and data stable until their done.
- The loser stays pending. It is granted in the next IDLE cycle if still requesting.
- stall = (i_req & ~i_done) | (d_req & ~d_done).
- mem_ack outside ISSUE is ignored.
- Writes (d_we=1) complete on mem_ack like reads. d_rdata is captured but meaningless for writes.

## Timing
- Reset values:
  - state = IDLE, last-grant = instruction;
  - mem_req, mem_we, i_done, d_done, err, busy, owner = 0;
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0;
  - stall follows its equation (0 with requests low).
- Latency:
  - req seen in IDLE at cycle t;
  - mem_req first high at t+1;
  - mem_ack at t+1+k gives done at t+2+k.
  - Minimum is 2 cycles (ack in the first ISSUE cycle).
- Back-to-back: after done at cycle n, the pending loser is registered at n+1 and mem_req rises at n+2.
- The data rdata registers hold their value until the next capture. done is a registered Moore output of RESP.
- Reset asserted in any state returns to IDLE in the next cycle and drops mem_req. No done is issued for the aborted transaction.

## Configuration
- REFILL_TIMEOUT_EN defined:
  - an 8-bit-or-wider counter clears on entry to ISSUE and increments each ISSUE cycle without mem_ack;
  - at count == TIMEOUT, the FSM goes to RESP with captured data 0, and err pulses together with the winner's done.
- Undefined: ISSUE waits indefinitely, err is tied to 0, and the counter is not built.

## Structure
- Package refill_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, RESP=2'd2;
  - owner constants OWNER_I=1'b0, OWNER_D=1'b1;
  - default ADDR_W, DATA_W, INSTR_W.
- Sub-module rr_arbiter2: two-request round-robin pick. Combinational grant from the requests plus the last-grant register. The update enable is driven by the parent in RESP.

## Test plan
- Single instruction miss: i_req with i_addr=0x40, mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF_00000013 -> mem_addr=0x40, mem_we=0, i_done one cycle later, i_rdata=0x00000013.
- Simultaneous i_req and d_req after reset -> data served first (owner=1), then instruction; on a second tie, instruction first.
- Data write: d_we=1, d_addr=0x100, d_wdata=0x55 -> mem_we=1, mem_wdata=0x55 held until mem_ack, d_done pulse, i_done stays 0.
- Reset in ISSUE: mem_req drops the next cycle, a later stray mem_ack gives no done pulse, and the state returns to IDLE.
- With REFILL_TIMEOUT_EN and TIMEOUT=4, no mem_ack -> done and err pulse together, rdata=0, and a pending request is granted next.
- stall: d_req held while the instruction transaction is in flight -> stall=1 until d_done.
